pattern_streamer: RTL and testbench
===================================

PATTERN_STREAMER -- requirements
Module: pattern_streamer

Interface
REQ-001 Parameter DW, default 6: ROM/FIFO data width in bits.
REQ-002 Parameter AW, default 11: ROM address width; AW SHALL be >= 3.
REQ-003 Parameter FDEPTH, default 16: FIFO depth in words; power of two, >= 4.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sel  input  2  pattern bank; start address = sel * 2^(AW-2), sampled on start.
REQ-007 len  input  AW-2  words per pass minus one (0 = 1 word), sampled on start.
REQ-008 mode  input  1  0 = one-shot, 1 = loop, sampled on start.
REQ-009 start  input  1  single-cycle request to begin streaming.
REQ-010 stop  input  1  abort streaming.
REQ-011 rom_addr  output  AW  registered ROM address.
REQ-012 rom_q  input  DW  ROM data, valid exactly 1 cycle after rom_addr.
REQ-013 rd_en  input  1  consumer read request.
REQ-014 data_out  output  DW  registered FIFO read data.
REQ-015 data_valid  output  1  data_out valid this cycle.
REQ-016 full / empty  output  1 each  FIFO status, registered.
REQ-017 level  output  $clog2(FDEPTH)+1  FIFO occupancy.
REQ-018 busy  output  1  high when FSM not in IDLE.

Function
REQ-019 FSM states: IDLE, RUN, FLUSH.
REQ-020 IDLE -> RUN on start; latch base, len, mode; offset counter := 0.
REQ-021 In RUN, an address issues (rom_addr := base + offset) only when level + inflight < FDEPTH; inflight = 1 if an address issued last cycle.
REQ-022 rom_q SHALL be written into the FIFO the cycle after its address issued; no write otherwise.
REQ-023 Offset increments per issue; at offset == len: mode 0 -> FLUSH; mode 1 -> offset := 0 (wrap), stay RUN.
REQ-024 FLUSH -> IDLE once the last in-flight word is written (1 cycle).
REQ-025 stop in RUN -> FLUSH; no further issues; in-flight word still written; stop in IDLE ignored.
REQ-026 start while busy ignored; start and stop same cycle in IDLE -> remain IDLE.
REQ-027 rd_en with empty=0: data_out := head word, data_valid := 1 next cycle; rd_en with empty=1 ignored, data_valid := 0.
REQ-028 Simultaneous read and write: level unchanged, both complete; FIFO SHALL never overflow or underflow.
REQ-029 full = (level == FDEPTH); empty = (level == 0); pointers wrap modulo FDEPTH.
REQ-030 Address arithmetic SHALL be AW bits; base + offset never exceeds bank (len is AW-2 bits).

Reset
REQ-031 rst SHALL, on the clock edge, set FSM to IDLE, offset 0, inflight 0, FIFO pointers 0.
REQ-032 Outputs after reset: rom_addr 0, data_out 0, data_valid 0, full 0, empty 1, level 0, busy 0.
REQ-033 rst mid-stream SHALL discard the in-flight word and all FIFO contents.

Structure
REQ-034 Shared package pattern_pkg SHALL hold the FSM state enum and mode constants.
REQ-035 FIFO SHALL be a sub-module sync_fifo (DW, FDEPTH), single clock, with level output.

Verification
REQ-036 sel=1, len=3, mode=0, start, rd_en held 1 -> rom_addr 512..515, four words out in order, busy falls after FLUSH.
REQ-037 FDEPTH=16, len=31, mode=0, rd_en=0 -> exactly 16 writes, full=1, level=16, no further issues; then rd_en -> remaining 16 words, no loss.
REQ-038 mode=1, len=2, rd_en=1 -> address sequence base, +1, +2, base, ... continues until stop.
REQ-039 stop asserted the cycle after an issue -> that word written, FSM IDLE next cycle, no further rom_addr changes.
REQ-040 rd_en on empty after reset -> data_valid 0, level 0; rst during RUN with level=5 -> level 0, empty 1, busy 0 next cycle.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types for the pattern streamer: FSM state encoding and pass modes.
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_LOOP    = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered full/empty and occupancy.
module sync_fifo #(
  parameter int DW     = 6,
  parameter int FDEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DW-1:0]           wr_data,
  input  logic                    rd_en,
  output logic [DW-1:0]           rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(FDEPTH):0] level
);
  localparam int PW = $clog2(FDEPTH);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(FDEPTH);

  logic [DW-1:0] mem_q [FDEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   level_q, level_d;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q, full_q, empty_q;
  logic          do_wr, do_rd;

  assign do_wr = wr_en && !full_q;
  assign do_rd = rd_en && !empty_q;

  always_comb begin
    level_d = level_q;
    if (do_wr && !do_rd)      level_d = level_q + (PW+1)'(1);
    else if (do_rd && !do_wr) level_d = level_q - (PW+1)'(1);
  end

  // Storage is not reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + PW'(1);
      if (do_rd) begin
        rptr_q    <= rptr_q + PW'(1);
        rd_data_q <= mem_q[rptr_q];
      end
      rd_valid_q <= do_rd;
      level_q    <= level_d;
      full_q     <= (level_d == DEPTH_W);
      empty_q    <= (level_d == '0);
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;

endmodule

// File: rtl/pattern_streamer.sv
// Streams a bank of ROM words into a FIFO, one-shot or looping, with flow
// control that counts every word still travelling through the ROM pipeline.
module pattern_streamer
  import pattern_pkg::*;
#(
  parameter int DW     = 6,
  parameter int AW     = 11,
  parameter int FDEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              sel,
  input  logic [AW-3:0]           len,
  input  logic                    mode,
  input  logic                    start,
  input  logic                    stop,
  output logic [AW-1:0]           rom_addr,
  input  logic [DW-1:0]           rom_q,
  input  logic                    rd_en,
  output logic [DW-1:0]           data_out,
  output logic                    data_valid,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(FDEPTH):0] level,
  output logic                    busy
);
  localparam int LW = $clog2(FDEPTH) + 1;
  localparam int OW = AW - 2;
  localparam logic [LW:0] DEPTH_W = (LW+1)'(FDEPTH);

  state_t        state_q;
  logic [AW-1:0] base_q, rom_addr_q;
  logic [OW-1:0] len_q, offset_q;
  logic          mode_q;
  logic          addr_vld_q;  // address on rom_addr this cycle
  logic          wr_vld_q;    // rom_q holds a word to be written this cycle
  logic [LW:0]   occ;
  logic          issue;

  // Occupancy includes both pipeline stages so an issued word always has room.
  assign occ   = {1'b0, level} + (LW+1)'(addr_vld_q) + (LW+1)'(wr_vld_q);
  assign issue = (state_q == ST_RUN) && !stop && (occ < DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      mode_q     <= MODE_ONESHOT;
      offset_q   <= '0;
      rom_addr_q <= '0;
      addr_vld_q <= 1'b0;
      wr_vld_q   <= 1'b0;
    end else begin
      addr_vld_q <= issue;
      wr_vld_q   <= addr_vld_q;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q  <= ST_RUN;
            base_q   <= {sel, {OW{1'b0}}};
            len_q    <= len;
            mode_q   <= mode;
            offset_q <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_FLUSH;
          end else if (issue) begin
            rom_addr_q <= base_q + {2'b00, offset_q};
            if (offset_q == len_q) begin
              if (mode_q == MODE_LOOP) offset_q <= '0;
              else                     state_q  <= ST_FLUSH;
            end else begin
              offset_q <= offset_q + OW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (!addr_vld_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != ST_IDLE);

  sync_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_vld_q),
    .wr_data  (rom_q),
    .rd_en    (rd_en),
    .rd_data  (data_out),
    .rd_valid (data_valid),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

endmodule

// File: tb/tb_pattern_streamer.sv
// Scoreboard bench for pattern_streamer: modelled synchronous ROM, expected
// addresses and words queued at stimulus time, popped as the DUT produces them.
module tb_pattern_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = '0;
  logic [8:0]  len = '0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] rom_addr;
  logic [5:0]  rom_q = '0;
  logic        rd_en = 1'b0;
  logic [5:0]  data_out;
  logic        data_valid;
  logic        full, empty;
  logic [4:0]  level;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [5:0]  exp_q[$];
  logic [10:0] addr_q[$];
  logic        addr_chk_en = 1'b0;
  logic [10:0] last_addr = '0;

  pattern_streamer #(.DW(6), .AW(11), .FDEPTH(16)) dut (
    .clk(clk), .rst(rst), .sel(sel), .len(len), .mode(mode), .start(start),
    .stop(stop), .rom_addr(rom_addr), .rom_q(rom_q), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rom_f(input logic [10:0] a);
    return a[5:0] ^ a[10:5];
  endfunction

  // Synchronous ROM: data for an address appears one cycle later.
  always @(posedge clk) rom_q <= rom_f(rom_addr);

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && data_valid) begin
      if (exp_q.size() == 0) chk("unexp_data_pending", exp_q.size(), 1);
      else                   chk("data", data_out, exp_q.pop_front());
    end
    if (addr_chk_en && rom_addr !== last_addr) begin
      if (addr_q.size() == 0) chk("unexp_addr_pending", addr_q.size(), 1);
      else                    chk("addr", rom_addr, addr_q.pop_front());
    end
    last_addr = rom_addr;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_run(input logic [10:0] base, input int n, input int wrap);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(base + 11'(i % wrap));
      exp_q.push_back(rom_f(base + 11'(i % wrap)));
    end
  endtask

  task automatic go(input logic [1:0] s, input logic [8:0] l, input logic m);
    sel = s; len = l; mode = m; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin cyc(1); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin cyc(1); n++; end
    chk(tag, exp_q.size(), 0);
    chk({tag, "_addr"}, addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_addr", rom_addr, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_dvalid", data_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);

    // read on empty, stop in idle, start+stop together
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    chk("empty_rd_valid", data_valid, 0);
    chk("empty_rd_level", level, 0);
    stop = 1'b1; cyc(1);
    start = 1'b1; cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(1);
    chk("start_stop_idle", busy, 0);

    // one-shot bank 1, four words, with an ignored restart while busy
    addr_chk_en = 1'b1;
    rd_en = 1'b1;
    push_run(11'd512, 4, 4);
    go(2'd1, 9'd3, 1'b0);
    chk("oneshot_busy", busy, 1);
    sel = 2'd2; len = 9'd0; start = 1'b1; cyc(1); start = 1'b0;
    wait_idle("oneshot_idle", 40);
    wait_drain("oneshot_drain", 40);
    chk("oneshot_last_addr", rom_addr, 515);

    // fill without reading: exactly FDEPTH words land, then issue stalls
    rd_en = 1'b0;
    push_run(11'd0, 32, 32);
    go(2'd0, 9'd31, 1'b0);
    cyc(60);
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    chk("fill_addr", rom_addr, 15);
    chk("fill_busy", busy, 1);
    cyc(5);
    chk("fill_stalled", rom_addr, 15);
    rd_en = 1'b1;
    wait_idle("fill_idle", 200);
    wait_drain("fill_drain", 100);
    chk("fill_empty", empty, 1);

    // loop mode, bank 2, three words per pass, stopped after some passes
    push_run(11'd1024, 30, 3);
    go(2'd2, 9'd2, 1'b1);
    for (int n = 0; n < 100 && addr_q.size() > 21; n++) cyc(1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    wait_idle("loop_idle", 10);
    cyc(8);
    chk("loop_wrapped", addr_q.size() <= 21 && addr_q.size() > 0, 1);
    chk("loop_left", exp_q.size(), addr_q.size());
    exp_q.delete(); addr_q.delete();

    // stop the cycle after the first issue
    push_run(11'd1536, 8, 8);
    go(2'd3, 9'd7, 1'b0);
    for (int n = 0; n < 10 && rom_addr != 11'd1536; n++) cyc(1);
    chk("stop_first_addr", rom_addr, 1536);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(1);
    chk("stop_idle", busy, 0);
    cyc(6);
    chk("stop_addr_hold", rom_addr, 1536);
    chk("stop_left", exp_q.size(), 7);
    chk("stop_addr_left", addr_q.size(), 7);
    exp_q.delete(); addr_q.delete();

    // reset mid-stream with data in the FIFO
    addr_chk_en = 1'b0;
    rd_en = 1'b0;
    go(2'd1, 9'd31, 1'b0);
    for (int n = 0; n < 40 && level < 5'd5; n++) cyc(1);
    chk("pre_rst_level", level >= 5'd5, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_full", full, 0);
    rd_en = 1'b1; cyc(2); rd_en = 1'b0;
    chk("mid_rst_discard", data_valid, 0);
    chk("mid_rst_level2", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
